// File: rtl/cdb_pkg.sv
// Common-data-bus shared definitions.
// Widths, FU identifiers and the broadcast bundle.
package cdb_pkg;

  localparam int CDB_N_FU    = 8;
  localparam int CDB_PTR_W   = 3;
  localparam int CDB_DATA_W  = 64;
  localparam int CDB_REG_W   = 5;
  localparam int CDB_FU_ID_W = 4;
  localparam int CDB_ISS_W   = 32;

  localparam logic [CDB_FU_ID_W-1:0] FU_ALU0 = 4'd0;
  localparam logic [CDB_FU_ID_W-1:0] FU_MEM  = 4'd1;
  localparam logic [CDB_FU_ID_W-1:0] FU_ALU1 = 4'd2;
  localparam logic [CDB_FU_ID_W-1:0] FU_MUL  = 4'd3;
  localparam logic [CDB_FU_ID_W-1:0] FU_DIV  = 4'd4;
  localparam logic [CDB_FU_ID_W-1:0] FU_BR   = 4'd5;
  localparam logic [CDB_FU_ID_W-1:0] FU_FPU0 = 4'd6;
  localparam logic [CDB_FU_ID_W-1:0] FU_FPU1 = 4'd7;

  typedef struct packed {
    logic [CDB_DATA_W-1:0]  data;
    logic [CDB_REG_W-1:0]   reg_id;
    logic [CDB_FU_ID_W-1:0] fu_id;
    logic [CDB_ISS_W-1:0]   iss_id;
  } cdb_bcast_t;

endpackage

// File: rtl/cdb_rr_pick.sv
// Circular priority encoder.
// First set req bit at or above ptr, wrapping to 0.
module cdb_rr_pick
  import cdb_pkg::*;
#(
  parameter int N     = CDB_N_FU,
  parameter int PTR_W = CDB_PTR_W
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  logic [PTR_W:0] w_j;

  // Scan N slots from ptr; explicit wrap keeps non-power-of-2 N correct
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_j      = '0;
    for (int k = 0; k < N; k++) begin
      w_j = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_j >= (PTR_W+1)'(N))
        w_j = w_j - (PTR_W+1)'(N);
      if (!o_any && i_req[w_j[PTR_W-1:0]]) begin
        o_any           = 1'b1;
        o_idx           = w_j[PTR_W-1:0];
        o_onehot[o_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB responder: round-robin grant and registered re-broadcast.
// Ack is combinational; the bus is sampled only on grant cycles.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_FU   = CDB_N_FU,
  parameter int PTR_W  = CDB_PTR_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_FU-1:0]        cdb_req,
  output logic [N_FU-1:0]        cdb_ack,
  input  logic                   rob_full,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      cdb_data,
  input  logic [CDB_REG_W-1:0]   cdb_reg_id,
  input  logic [CDB_FU_ID_W-1:0] cdb_fu_id,
  input  logic [CDB_ISS_W-1:0]   cdb_iss_id,
  output logic                   bcast_valid,
  output logic [DATA_W-1:0]      bcast_data,
  output logic [CDB_REG_W-1:0]   bcast_reg_id,
  output logic [CDB_FU_ID_W-1:0] bcast_fu_id,
  output logic [CDB_ISS_W-1:0]   bcast_iss_id,
  output logic                   fu_id_err
);

  logic [PTR_W-1:0]       r_ptr;
  logic                   r_valid;
  logic [DATA_W-1:0]      r_data;
  logic [CDB_REG_W-1:0]   r_reg_id;
  logic [CDB_FU_ID_W-1:0] r_fu_id;
  logic [CDB_ISS_W-1:0]   r_iss_id;
  logic                   r_err;

  logic [N_FU-1:0]        w_onehot;
  logic [PTR_W-1:0]       w_idx;
  logic                   w_any;
  logic                   w_gnt_en;
  logic                   w_gnt;
  logic [CDB_FU_ID_W-1:0] w_gnt_id;

  cdb_rr_pick #(
    .N     (N_FU),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req    (cdb_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_gnt_en = !reset && !rob_full && !flush;
  assign w_gnt    = w_gnt_en && w_any;
  assign w_gnt_id = CDB_FU_ID_W'(w_idx);
  assign cdb_ack  = w_gnt ? w_onehot : '0;

  // Advance the pointer past the winner, wrapping at N_FU-1
  always_ff @(posedge clk) begin
    if (reset)
      r_ptr <= '0;
    else if (w_gnt)
      r_ptr <= (w_idx == PTR_W'(N_FU-1)) ? '0 : w_idx + PTR_W'(1);
  end

  // Capture the bus on grant; payload holds otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_reg_id <= '0;
      r_fu_id  <= '0;
      r_iss_id <= '0;
    end else begin
      r_valid <= w_gnt;
      if (w_gnt) begin
        r_data   <= cdb_data;
        r_reg_id <= cdb_reg_id;
        r_fu_id  <= w_gnt_id;
        r_iss_id <= cdb_iss_id;
      end
    end
  end

  // Sticky flag: FU drove an id that differs from the granted index
  always_ff @(posedge clk) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_gnt && (cdb_fu_id != w_gnt_id))
      r_err <= 1'b1;
  end

  assign bcast_valid  = r_valid;
  assign bcast_data   = r_data;
  assign bcast_reg_id = r_reg_id;
  assign bcast_fu_id  = r_fu_id;
  assign bcast_iss_id = r_iss_id;
  assign fu_id_err    = r_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter.
// Model FUs drive the shared bus only while acked.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [7:0]  ack;
  logic        rob_full;
  logic        flush;
  logic [63:0] bus_data;
  logic [4:0]  bus_reg;
  logic [3:0]  bus_fu;
  logic [31:0] bus_iss;
  logic        b_valid;
  logic [63:0] b_data;
  logic [4:0]  b_reg;
  logic [3:0]  b_fu;
  logic [31:0] b_iss;
  logic        err;

  logic [63:0] fu_data [8];
  logic [4:0]  fu_reg  [8];
  logic [3:0]  fu_fu   [8];
  logic [31:0] fu_iss  [8];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .cdb_req      (req),
    .cdb_ack      (ack),
    .rob_full     (rob_full),
    .flush        (flush),
    .cdb_data     (bus_data),
    .cdb_reg_id   (bus_reg),
    .cdb_fu_id    (bus_fu),
    .cdb_iss_id   (bus_iss),
    .bcast_valid  (b_valid),
    .bcast_data   (b_data),
    .bcast_reg_id (b_reg),
    .bcast_fu_id  (b_fu),
    .bcast_iss_id (b_iss),
    .fu_id_err    (err)
  );

  // Acked FU drives the bus; otherwise it floats
  always_comb begin
    bus_data = 'z;
    bus_reg  = 'z;
    bus_fu   = 'z;
    bus_iss  = 'z;
    for (int i = 0; i < 8; i++) begin
      if (ack[i]) begin
        bus_data = fu_data[i];
        bus_reg  = fu_reg[i];
        bus_fu   = fu_fu[i];
        bus_iss  = fu_iss[i];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req   = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      fu_data[i] = 64'h1000 + 64'(i);
      fu_reg[i]  = 5'(i + 8);
      fu_fu[i]   = 4'(i);
      fu_iss[i]  = 32'(100 + i);
    end
    fu_data[1] = 64'hDEAD;
    fu_reg[1]  = 5'd5;
    fu_iss[1]  = 32'd7;
    reset    = 1'b1;
    req      = 8'hFF;
    rob_full = 1'b0;
    flush    = 1'b0;
    #1;
    chk("ack_in_reset", 64'(ack), 64'h0);
    step();
    req = '0;
    step();
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_valid", 64'(b_valid), 64'h0);
    chk("rst_data", b_data, 64'h0);
    chk("rst_fu", 64'(b_fu), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    reset = 1'b0;

    req = 8'h02;
    #1;
    chk("t2_ack", 64'(ack), 64'h02);
    step();
    chk("t2_valid", 64'(b_valid), 64'h1);
    chk("t2_data", b_data, 64'hDEAD);
    chk("t2_reg", 64'(b_reg), 64'd5);
    chk("t2_fu", 64'(b_fu), 64'd1);
    chk("t2_iss", 64'(b_iss), 64'd7);
    req = 8'h06;
    #1;
    chk("t2_ptr2_ack", 64'(ack), 64'h04);
    reset = 1'b1;
    #1;
    chk("rst_mid_ack", 64'(ack), 64'h0);
    step();
    chk("rst_mid_valid", 64'(b_valid), 64'h0);
    chk("rst_mid_data", b_data, 64'h0);
    reset = 1'b0;
    req   = '0;
    step();

    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk($sformatf("t3_ack%0d", k), 64'(ack), 64'(1) << (k % 8));
      step();
      chk($sformatf("t3_fu%0d", k), 64'(b_fu), 64'(k % 8));
      chk($sformatf("t3_data%0d", k), b_data, fu_data[k % 8]);
    end
    do_reset();

    req      = 8'h22;
    rob_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_full_ack", 64'(ack), 64'h0);
      step();
      chk("t4_full_valid", 64'(b_valid), 64'h0);
    end
    rob_full = 1'b0;
    #1;
    chk("t4_ack", 64'(ack), 64'h02);
    step();
    chk("t4_valid", 64'(b_valid), 64'h1);
    chk("t4_fu", 64'(b_fu), 64'd1);

    req   = 8'h02;
    flush = 1'b1;
    #1;
    chk("t5_flush_ack", 64'(ack), 64'h0);
    step();
    chk("t5_flush_valid", 64'(b_valid), 64'h0);
    flush = 1'b0;
    #1;
    chk("t5_ack", 64'(ack), 64'h02);
    step();
    chk("t5_valid", 64'(b_valid), 64'h1);
    req = '0;
    step();
    chk("t5_one_bcast", 64'(b_valid), 64'h0);
    chk("t5_hold_data", b_data, 64'hDEAD);
    chk("t5_no_err", 64'(err), 64'h0);

    fu_fu[3] = 4'd1;
    req = 8'h08;
    #1;
    chk("t6_ack", 64'(ack), 64'h08);
    step();
    chk("t6_err", 64'(err), 64'h1);
    chk("t6_fu", 64'(b_fu), 64'd3);
    req = '0;
    step();
    step();
    chk("t6_sticky", 64'(err), 64'h1);
    reset = 1'b1;
    step();
    chk("t6_err_clr", 64'(err), 64'h0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
